// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   op_t    - funct3 operation encodings
//   state_t - sequencing states of muldiv_unit
//   DIV_ZERO_Q / INT_MIN - special-case result constants
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic is_div(input op_t o);
    return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// div_core: unsigned restoring divider datapath, one quotient bit per step.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   load_i        - capture dividend/divisor and clear the partial remainder
//   step_i        - perform one shift-subtract step
//   dividend_i    - unsigned dividend
//   divisor_i     - unsigned divisor
//   quo_next_o    - quotient after the current step (combinational)
//   rem_next_o    - remainder after the current step (combinational)
// The next-step values are exported so the owner can register the final
// answer in the same cycle as the last step.
module div_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] quo_next_o,
  output logic [DATA_WIDTH-1:0] rem_next_o
);

  localparam int unsigned W = DATA_WIDTH;

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dvs_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // quo_q starts as the dividend; its MSB feeds the remainder each step while
  // quotient bits enter at the LSB. The remainder stays below the divisor, so
  // the shifted value always fits in W+1 bits.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[W]) begin
      rem_d = diff[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_d = shifted[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quo_next_o = quo_d;
  assign rem_next_o = rem_d;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with start/busy/done.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - launch request (sampled only when idle)
//   kill      - abort in-flight operation; also blocks a launch
//   op        - funct3 operation code
//   src_a     - rs1 / dividend / multiplicand
//   src_b     - rs2 / divisor / multiplier
//   busy      - high while not idle
//   done      - one-cycle pulse with result valid
//   result    - registered result, held until the next done
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiplier for the four multiply ops; otherwise multiplies iterate.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kill,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q;
  op_t            op_q;
  logic           neg_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   mcand_q;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   result_q;
  logic           done_q;
  logic           busy_q;

  op_t            op_in;
  logic           a_sgn, b_sgn, neg_d;
  logic [W-1:0]   mag_a, mag_b;
  logic           special;
  logic [W-1:0]   spec_res;
  logic           launch;
  logic [W:0]     add_sum;
  logic [2*W-1:0] prod_d;
  logic [W-1:0]   final_res;
  logic [W-1:0]   quo_next, rem_next;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
`endif

  function automatic logic [W-1:0] mul_pick(input logic [2*W-1:0] p, input logic neg,
                                            input op_t o);
    logic [2*W-1:0] s;
    s = neg ? -p : p;
    return (o == OP_MUL) ? s[W-1:0] : s[2*W-1:W];
  endfunction

  // neg carries the quotient sign for DIV/DIVU and the dividend sign for REM/REMU.
  function automatic logic [W-1:0] div_pick(input logic [W-1:0] q, input logic [W-1:0] r,
                                            input logic neg, input op_t o);
    logic [W-1:0] v;
    v = (o inside {OP_DIV, OP_DIVU}) ? q : r;
    return neg ? -v : v;
  endfunction

  // Operand decode, magnitudes and special-case detection (used only in IDLE).
  always_comb begin
    op_in  = op_t'(op);
    a_sgn  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && src_a[W-1];
    b_sgn  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && src_b[W-1];
    mag_a  = a_sgn ? -src_a : src_a;
    mag_b  = b_sgn ? -src_b : src_b;
    neg_d  = (op_in == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
    launch = (state_q == ST_IDLE) && start && !kill;
    special  = 1'b0;
    spec_res = '0;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`endif
    if (is_div(op_in) && (src_b == '0)) begin
      special  = 1'b1;
      spec_res = (op_in inside {OP_DIV, OP_DIVU}) ? DIV_ZERO_Q : src_a;
    end else if ((op_in inside {OP_DIV, OP_REM}) && (src_a == INT_MIN) && (src_b == '1)) begin
      special  = 1'b1;
      spec_res = (op_in == OP_DIV) ? INT_MIN : '0;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div(op_in)) begin
      special  = 1'b1;
      spec_res = mul_pick(fast_prod, neg_d, op_in);
    end
`endif
  end

  // One shift-add multiply step; final answers are taken from the next-step
  // values so result registers together with the last iteration.
  always_comb begin
    add_sum   = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? mcand_q : {W{1'b0}})};
    prod_d    = {add_sum, prod_q[W-1:1]};
    final_res = is_div(op_q) ? div_pick(quo_next, rem_next, neg_q, op_q)
                             : mul_pick(prod_d, neg_q, op_q);
  end

  div_core #(
    .DATA_WIDTH(W)
  ) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (launch),
    .step_i     ((state_q == ST_CALC) && is_div(op_q)),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quo_next_o (quo_next),
    .rem_next_o (rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (launch) begin
            op_q    <= op_in;
            neg_q   <= neg_d;
            cnt_q   <= '0;
            mcand_q <= mag_a;
            prod_q  <= {{W{1'b0}}, mag_b};
            busy_q  <= 1'b1;
            if (special) begin
              result_q <= spec_res;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            prod_q <= prod_d;
            if (cnt_q == LAST) begin
              result_q <= final_res;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the RV32M arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2]) begin
      if (b == 0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Called at a negedge; start is sampled at the following posedge (cycle N),
  // so iteration k of the loop observes cycle N+k.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
    int lat, ndone, first, busy_bad;
    logic [31:0] res_at;
    lat = exp_lat(o, a, b);
    ndone = 0; first = 0; busy_bad = 0; res_at = '0;
    op = o; src_a = a; src_b = b; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== (k <= lat)) busy_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin first = k; res_at = result; end
      end
    end
    chk({nm, " result"}, res_at, exp);
    chk({nm, " done cycle"}, first, lat);
    chk({nm, " done count"}, ndone, 1);
    chk({nm, " busy window"}, busy_bad, 0);
    chk({nm, " result hold"}, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[14];

  initial begin
    int ndone, first;
    logic [31:0] prev, ra, rb;
    logic [2:0]  ro;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3"};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU"};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "MULH"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, "MULHSU"};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2"};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7%2"};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        "DIVU 100/7"};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         "REMU 100%7"};
    vecs[8]  = '{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, "DIVU by 0"};
    vecs[9]  = '{3'd7, 32'h1234,       32'd0,         32'h1234,      "REMU by 0"};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "REM ovf"};
    vecs[12] = '{3'd4, 32'd55,         32'd0,         32'hFFFF_FFFF, "DIV by 0"};
    vecs[13] = '{3'd6, 32'h8000_0005,  32'd0,         32'h8000_0005, "REM by 0"};

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Kill mid-divide: no done, result untouched, immediate relaunch works.
    prev = result;
    op = 3'd4; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) ndone++;
      if (k == 10) begin
        chk("kill busy before", busy, 1);
        kill = 1'b1;
      end
      if (k == 11) begin
        kill = 1'b0;
        chk("kill busy after", busy, 0);
      end
    end
    chk("kill no done", ndone, 0);
    chk("kill result kept", result, prev);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "after kill");

    // start and kill together while idle: nothing launches.
    op = 3'd5; src_a = 32'd9; src_b = 32'd0; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("start+kill busy", busy, 0);
    @(negedge clk);
    chk("start+kill done", done, 0);

    // start held high through an operation: single done.
    op = 3'd5; src_a = 32'd50; src_b = 32'd5; start = 1'b1;
    ndone = 0; first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) start = 1'b0;
      if (done === 1'b1) begin ndone++; if (first == 0) first = k; end
    end
    chk("held start count", ndone, 1);
    chk("held start cycle", first, 33);
    chk("held start result", result, 10);

    // Reset mid-operation.
    op = 3'd7; src_a = 32'd77; src_b = 32'd5; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst result", result, 0);
      end
      if (done === 1'b1) ndone++;
    end
    chk("midrst no done", ndone, 0);

    for (int i = 0; i < 120; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d op%0d", i, ro));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
